fb_scan_ctrl: RTL

- Parametrised framebuffer scan controller that generates read addresses for the display port of the pixel RAM and returns pixels with a valid strobe.
- Successor to the fixed 16-bit free-running pixel-address counter.
- Adds configurable image size, integer up-scaling, request/valid handshake, RAM read-latency tracking, correct end-of-frame wrap and frame-done signalling.
- Sits between the pixel RAM read port and the VGA output logic, in the CPU clock domain.

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_valid_pipe.sv | 35 +++
 rtl/fb_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared state type and sizing helpers for the framebuffer scan controller.
package fb_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} fb_state_t;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic longint unsigned frame_pix(input int unsigned w, input int unsigned h);
      return 64'(w) * 64'(h);
   endfunction

endpackage

// File: rtl/fb_valid_pipe.sv
// Read-latency tracker: DEPTH-stage shift register of {valid, last} tags.
module fb_valid_pipe #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last,
   output logic empty
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] l_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         v_q <= '0;
         l_q <= '0;
      end else begin
         v_q[0] <= in_valid;
         l_q[0] <= in_valid & in_last;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
         end
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_last  = l_q[DEPTH-1];
   assign empty     = ~|v_q;

endmodule

// File: rtl/fb_scan_ctrl.sv
// Framebuffer scan controller: scaled raster read addresses, latency-tracked pixel return.
// Optional double-buffered display bank selected by FB_DOUBLE_BUFFER_EN.
module fb_scan_ctrl
   import fb_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned IMG_W  = 256,
   parameter int unsigned IMG_H  = 256,
   parameter int unsigned SCALE  = 1,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              pix_req,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [PIX_W-1:0]  ram_q,
   output logic [PIX_W-1:0]  pixel,
   output logic              pixel_valid,
   output logic              frame_done,
   output logic              busy
`ifdef FB_DOUBLE_BUFFER_EN
   ,
   input  logic              swap_req,
   output logic              disp_bank
`endif
);

   localparam int unsigned XW = cnt_w(IMG_W);
   localparam int unsigned YW = cnt_w(IMG_H);
   localparam int unsigned SW = cnt_w(SCALE);
   localparam longint unsigned FRAME_PIX = frame_pix(IMG_W, IMG_H);
`ifdef FB_DOUBLE_BUFFER_EN
   localparam longint unsigned NBANK = 2;
`else
   localparam longint unsigned NBANK = 1;
`endif

   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

   if (SCALE < 1 || RD_LAT < 1 || IMG_W < 1 || IMG_H < 1) begin : g_bad_dims
      $error("fb_scan_ctrl: SCALE, RD_LAT, IMG_W and IMG_H must all be >= 1");
   end
   if (FRAME_PIX * NBANK > (64'd1 << ADDR_W)) begin : g_bad_addr_w
      $error("fb_scan_ctrl: image does not fit in ADDR_W address bits");
   end

   fb_state_t         state_q, state_nxt;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [SW-1:0]     hsub_q, vsub_q;
   logic [ADDR_W-1:0] row_base_q;
   logic [ADDR_W-1:0] bank_off;
   logic              accept, last_req, drained;
   logic              issue_v_q, issue_last_q;
   logic              pipe_v, pipe_l, pipe_empty;

   assign accept   = (state_q == SCAN) && enable && pix_req;
   assign last_req = (x_q == X_LAST) && (y_q == Y_LAST) && (hsub_q == S_LAST) && (vsub_q == S_LAST);
   assign drained  = pipe_empty && !issue_v_q;

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (enable)  state_nxt = SCAN;
         SCAN:    if (!enable) state_nxt = DRAIN;
         DRAIN:   if (drained) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Raster walk with horizontal/vertical repeat; a row is replayed by leaving row_base alone.
   always_ff @(posedge clk) begin
      if (!reset || state_nxt == IDLE || (accept && last_req)) begin
         x_q        <= '0;
         y_q        <= '0;
         hsub_q     <= '0;
         vsub_q     <= '0;
         row_base_q <= '0;
      end else if (accept) begin
         if (hsub_q != S_LAST) begin
            hsub_q <= hsub_q + 1'b1;
         end else begin
            hsub_q <= '0;
            if (x_q != X_LAST) begin
               x_q <= x_q + 1'b1;
            end else begin
               x_q <= '0;
               if (vsub_q != S_LAST) begin
                  vsub_q <= vsub_q + 1'b1;
               end else begin
                  vsub_q     <= '0;
                  y_q        <= y_q + 1'b1;
                  row_base_q <= row_base_q + ADDR_W'(IMG_W);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ram_addr     <= '0;
         issue_v_q    <= 1'b0;
         issue_last_q <= 1'b0;
      end else begin
         issue_v_q    <= accept;
         issue_last_q <= accept & last_req;
         if (accept) ram_addr <= bank_off + row_base_q + ADDR_W'(x_q);
      end
   end

`ifdef FB_DOUBLE_BUFFER_EN
   logic bank_q, swap_pend_q;

   // A swap arriving with the last request takes effect at that same boundary.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bank_q      <= 1'b0;
         swap_pend_q <= 1'b0;
      end else if (accept && last_req && (swap_pend_q || swap_req)) begin
         bank_q      <= ~bank_q;
         swap_pend_q <= 1'b0;
      end else if (swap_req) begin
         swap_pend_q <= 1'b1;
      end
   end

   assign disp_bank = bank_q;
   assign bank_off  = bank_q ? ADDR_W'(FRAME_PIX) : '0;
`else
   assign bank_off = '0;
`endif

   fb_valid_pipe #(
      .DEPTH (RD_LAT)
   ) u_valid_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (issue_v_q),
      .in_last   (issue_last_q),
      .out_valid (pipe_v),
      .out_last  (pipe_l),
      .empty     (pipe_empty)
   );

   assign pixel_valid = pipe_v;
   assign frame_done  = pipe_v & pipe_l;
   assign pixel       = pipe_v ? ram_q : '0;
   assign busy        = (state_q != IDLE);

endmodule
